buffer_in: RTL

BUFFER_IN -- requirements
Module: buffer_in

---
 rtl/buffer_in.sv | 116 +++++++++++
 1 files changed

// File: rtl/buffer_in.sv
// Stream-to-parallel frame capture: collects MEM_DEPTH 64-bit beats from an
// AXI-Stream source into a register frame and holds it until the consumer acks.
module buffer_in #(
  parameter int MEM_DEPTH  = 3,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [63:0]               s_tdata,
  input  logic                      s_tvalid,
  input  logic                      s_tlast,
  output logic                      s_tready,
  output logic [MEM_DEPTH*64-1:0]   dout,
  output logic                      data_valid,
  input  logic                      data_ack,
  output logic                      err_len,
  output logic [7:0]                frame_cnt,
  output logic [1:0]                state_dbg,
  output logic [ADDR_WIDTH-1:0]     wr_ptr_dbg
);

  // Handshake: a beat transfers on a rising edge when s_tvalid and s_tready
  // are both 1. s_tready depends only on registered state (and reset), never
  // on s_tvalid. The frame side is a level: data_valid holds until data_ack.

  typedef enum logic [1:0] {
    FILL = 2'd0,
    SKIP = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(MEM_DEPTH - 1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [63:0]             mem [MEM_DEPTH];
  logic                    hs;

  assign s_tready   = rst_n && (state != FULL);
  assign hs         = s_tvalid && s_tready;
  assign state_dbg  = state;
  assign wr_ptr_dbg = wr_ptr;

  always_comb begin
    dout = '0;
    for (int i = 0; i < MEM_DEPTH; i++) begin
      dout[64*i +: 64] = mem[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FILL;
      wr_ptr     <= '0;
      data_valid <= 1'b0;
      err_len    <= 1'b0;
      frame_cnt  <= 8'd0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= 64'd0;
      end
    end else begin
      err_len <= 1'b0;
      case (state)
        FILL: begin
          if (hs) begin
            if (s_tlast && (wr_ptr < LAST_PTR)) begin
              // Short frame: drop it and start over at word 0.
              err_len <= 1'b1;
              wr_ptr  <= '0;
            end else begin
              for (int i = 0; i < MEM_DEPTH; i++) begin
                if (wr_ptr == ADDR_WIDTH'(i)) begin
                  mem[i] <= s_tdata;
                end
              end
              if (wr_ptr == LAST_PTR) begin
                wr_ptr <= '0;
                if (s_tlast) begin
                  state      <= FULL;
                  data_valid <= 1'b1;
                  frame_cnt  <= frame_cnt + 8'd1;
                end else begin
                  // Frame is complete but the transfer runs on: flush the rest.
                  state   <= SKIP;
                  err_len <= 1'b1;
                end
              end else begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
              end
            end
          end
        end
        SKIP: begin
          if (hs && s_tlast) begin
            state      <= FULL;
            data_valid <= 1'b1;
            frame_cnt  <= frame_cnt + 8'd1;
          end
        end
        FULL: begin
          if (data_ack) begin
            state      <= FILL;
            data_valid <= 1'b0;
            wr_ptr     <= '0;
          end
        end
        default: begin
          state      <= FILL;
          data_valid <= 1'b0;
          wr_ptr     <= '0;
        end
      endcase
    end
  end

endmodule
